// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM ramp controller: FSM states,
// reset values and command normalisation helpers.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        DONE
    } state_t;

    localparam int unsigned MAX_W  = 32;
    localparam int unsigned MAX_W1 = MAX_W + 1;

    localparam int unsigned DEFAULT_DUTY = 0;

    // All-ones of width w, computed one bit wider so w == MAX_W works too.
    function automatic logic [MAX_W-1:0] default_max(input int unsigned w);
        return MAX_W'((MAX_W1'(1) << w) - MAX_W1'(1));
    endfunction

    function automatic logic [MAX_W-1:0] norm_step(input logic [MAX_W-1:0] s);
        return (s == '0) ? MAX_W'(1) : s;
    endfunction

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational saturating step: moves current toward target by step
// without overshooting, and flags when target is reached.
module pwm_ramp_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next,
    output logic             reached
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] gap;

    always_comb begin
        sum  = {1'b0, current} + {1'b0, step};
        gap  = '0;
        next = current;
        if (current < target) begin
            // Extra bit keeps the upward sum from wrapping below target.
            next = (sum >= {1'b0, target}) ? target : sum[WIDTH-1:0];
        end else if (current > target) begin
            gap  = current - target;
            next = (step >= gap) ? target : current - step;
        end else begin
            next = target;
        end
        reached = (next == target);
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Command-driven duty ramp sequencer for the PWM generator; all duty and
// max_value updates land on period_end boundaries.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_end,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_target,
    input  logic [WIDTH-1:0]  cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [WIDTH-1:0]  cmd_max,
    input  logic              abort,
    output logic [WIDTH-1:0]  duty_out,
    output logic [WIDTH-1:0]  max_out,
    output logic              busy,
    output logic              done
);

    state_t state, state_next;

    logic [WIDTH-1:0]  target_q;
    logic [WIDTH-1:0]  step_q;
    logic [WIDTH-1:0]  max_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              first_q;
    logic              fin_q;

    logic              accept;
    logic              do_step;
    logic              hold_load;
    logic              hold_dec;
    logic [WIDTH-1:0]  next_duty;
    logic              reached;

    pwm_ramp_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .current (duty_out),
        .target  (target_q),
        .step    (step_q),
        .next    (next_duty),
        .reached (reached)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_step    = 1'b0;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = !abort;
                if (cmd_valid && !abort) begin
                    accept     = 1'b1;
                    state_next = RAMP;
                end
            end
            RAMP: begin
                busy = 1'b1;
                // fin_q holds RAMP one extra cycle so done trails the final duty.
                if (abort) begin
                    state_next = IDLE;
                end else if (fin_q) begin
                    state_next = DONE;
                end else if (period_end) begin
                    if (first_q || hold_cnt == '0) begin
                        do_step   = 1'b1;
                        hold_load = !reached;
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_out <= WIDTH'(DEFAULT_DUTY);
            max_out  <= WIDTH'(default_max(WIDTH));
            target_q <= '0;
            step_q   <= '0;
            max_q    <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
            first_q  <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            if (accept) begin
                target_q <= (cmd_target < cmd_max) ? cmd_target : cmd_max;
                step_q   <= WIDTH'(norm_step(MAX_W'(cmd_step)));
                hold_q   <= cmd_hold;
                max_q    <= cmd_max;
                hold_cnt <= '0;
                first_q  <= 1'b1;
                fin_q    <= 1'b0;
            end
            if (do_step) begin
                duty_out <= next_duty;
                first_q  <= 1'b0;
                fin_q    <= reached;
                if (first_q) begin
                    max_out <= max_q;
                end
            end
            if (hold_load) begin
                hold_cnt <= hold_q;
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule
